// File: rtl/y86_fetch_decode_if.sv
// Fetch/decode bus for y86_fetch_decode.
// The master side drives the fetch PC, the program-load port and the
// register-file write port. The slave side (the fetch/decode block) returns
// the decoded fields, valP, the status flags, the operands and the write
// error flag.
interface y86_fetch_decode_if;
  logic [63:0] PC;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [7:0]  imem_wdata;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic        mem_error;
  logic        func_error;
  logic        halt;
  logic        nop;
  logic [63:0] valA;
  logic [63:0] valB;
  logic        write;
  logic [3:0]  wr_addr;
  logic [63:0] data_in;
  logic        err;

  modport master (
    output PC, imem_we, imem_addr, imem_wdata, write, wr_addr, data_in,
    input  icode, ifun, rA, rB, valC, valP, mem_error, func_error, halt, nop,
           valA, valB, err
  );

  modport slave (
    input  PC, imem_we, imem_addr, imem_wdata, write, wr_addr, data_in,
    output icode, ifun, rA, rB, valC, valP, mem_error, func_error, halt, nop,
           valA, valB, err
  );
endinterface

// File: rtl/y86_fetch_decode.sv
// Y86-64 sequential front end: fetch from an internal byte-addressed
// instruction memory, field split, valP computation, and the 15-entry
// register file (combinational reads on the fetched rA/rB, one synchronous
// write port).
// Ports: clk, reset (synchronous, active high), bus (slave modport of
// y86_fetch_decode_if carrying PC, program load, decoded outputs, operands
// and the register write port).
module y86_fetch_decode #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input logic               clk,
  input logic               reset,
  y86_fetch_decode_if.slave bus
);

  localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0, I_NOP   = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ   = 4'h6, I_JXX    = 4'h7,
    I_CALL   = 4'h8, I_RET   = 4'h9, I_PUSHQ  = 4'hA, I_POPQ   = 4'hB
  } icode_e;

  logic [7:0]  imem [MEM_BYTES];
  logic [63:0] regs [15];
  logic [7:0]  ib [10];

  logic [3:0]  n_icode, n_ifun, n_rA, n_rB, len;
  logic [63:0] n_valC, n_valP, a, last_addr;
  logic        n_mem_error, n_func_error, n_halt, n_nop;
  logic        ifun_ok, has_regs, valc_at1, valc_at2;

  // Ten bytes starting at PC; bytes beyond the memory read as zero so the
  // window never indexes out of range.
  always_comb begin
    a = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      a = bus.PC + 64'(i);
      ib[i] = (a < MEM_LIMIT) ? imem[a[AW-1:0]] : '0;
    end
  end

  always_comb begin
    len      = 4'd1;
    ifun_ok  = 1'b0;
    has_regs = 1'b0;
    valc_at1 = 1'b0;
    valc_at2 = 1'b0;
    case (ib[0][7:4])
      I_HALT, I_NOP, I_RET: ifun_ok = (ib[0][3:0] == 4'h0);
      I_RRMOVQ: begin len = 4'd2; has_regs = 1'b1; ifun_ok = (ib[0][3:0] <= 4'd6); end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        len = 4'd10; has_regs = 1'b1; valc_at2 = 1'b1; ifun_ok = (ib[0][3:0] == 4'h0);
      end
      I_OPQ: begin len = 4'd2; has_regs = 1'b1; ifun_ok = (ib[0][3:0] <= 4'd3); end
      I_JXX: begin len = 4'd9; valc_at1 = 1'b1; ifun_ok = (ib[0][3:0] <= 4'd6); end
      I_CALL: begin len = 4'd9; valc_at1 = 1'b1; ifun_ok = (ib[0][3:0] == 4'h0); end
      I_PUSHQ, I_POPQ: begin len = 4'd2; has_regs = 1'b1; ifun_ok = (ib[0][3:0] == 4'h0); end
      default: ifun_ok = 1'b0;
    endcase

    // An illegal instruction is treated as one byte long, both for valP and
    // for the memory bound check.
    if (!ifun_ok) len = 4'd1;
    last_addr   = bus.PC + 64'(len) - 64'd1;
    n_mem_error = (bus.PC >= MEM_LIMIT) || (last_addr >= MEM_LIMIT);

    n_icode      = ib[0][7:4];
    n_ifun       = ib[0][3:0];
    n_rA         = has_regs ? ib[1][7:4] : 4'hF;
    n_rB         = has_regs ? ib[1][3:0] : 4'hF;
    n_valC       = valc_at2 ? {ib[9], ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2]} :
                   valc_at1 ? {ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2], ib[1]} : '0;
    n_valP       = bus.PC + 64'(len);
    n_func_error = !ifun_ok;
    n_halt       = ifun_ok && (ib[0][7:4] == I_HALT);
    n_nop        = ifun_ok && (ib[0][7:4] == I_NOP);

    if (!ifun_ok) begin
      n_rA   = 4'hF;
      n_rB   = 4'hF;
      n_valC = '0;
    end
    if (n_mem_error) begin
      n_icode      = '0;
      n_ifun       = '0;
      n_rA         = 4'hF;
      n_rB         = 4'hF;
      n_valC       = '0;
      n_valP       = bus.PC;
      n_func_error = 1'b0;
      n_halt       = 1'b0;
      n_nop        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.icode      <= '0;
      bus.ifun       <= '0;
      bus.rA         <= 4'hF;
      bus.rB         <= 4'hF;
      bus.valC       <= '0;
      bus.valP       <= '0;
      bus.mem_error  <= 1'b0;
      bus.func_error <= 1'b0;
      bus.halt       <= 1'b0;
      bus.nop        <= 1'b0;
    end else begin
      bus.icode      <= n_icode;
      bus.ifun       <= n_ifun;
      bus.rA         <= n_rA;
      bus.rB         <= n_rB;
      bus.valC       <= n_valC;
      bus.valP       <= n_valP;
      bus.mem_error  <= n_mem_error;
      bus.func_error <= n_func_error;
      bus.halt       <= n_halt;
      bus.nop        <= n_nop;
    end
  end

  // Program memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.imem_we && (bus.imem_addr < MEM_LIMIT))
      imem[bus.imem_addr[AW-1:0]] <= bus.imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 15; i++) regs[i] <= '0;
    end else if (bus.write && (bus.wr_addr != 4'hF)) begin
      regs[bus.wr_addr] <= bus.data_in;
    end
  end

  assign bus.valA = (bus.rA == 4'hF) ? '0 : regs[bus.rA];
  assign bus.valB = (bus.rB == 4'hF) ? '0 : regs[bus.rB];
  assign bus.err  = bus.write && (bus.wr_addr == 4'hF);

endmodule

// File: tb/tb_y86_fetch_decode.sv
module tb_y86_fetch_decode;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  y86_fetch_decode_if bus ();

  y86_fetch_decode #(.MEM_BYTES(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [63:0] addr, input logic [7:0] data);
    bus.imem_we    = 1'b1;
    bus.imem_addr  = addr;
    bus.imem_wdata = data;
    step();
    bus.imem_we    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.PC = 64'd0;
    step();
    step();
    checks++; if (bus.icode !== 4'h0) begin errors++; $display("FAIL reset_icode got %h want 0", bus.icode); end
    checks++; if (bus.ifun !== 4'h0) begin errors++; $display("FAIL reset_ifun got %h want 0", bus.ifun); end
    checks++; if (bus.rA !== 4'hF || bus.rB !== 4'hF) begin errors++; $display("FAIL reset_regs got %h/%h want f/f", bus.rA, bus.rB); end
    checks++; if (bus.valC !== 64'd0 || bus.valP !== 64'd0) begin errors++; $display("FAIL reset_vals got %h/%h want 0/0", bus.valC, bus.valP); end
    checks++; if ({bus.mem_error, bus.func_error, bus.halt, bus.nop, bus.err} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {bus.mem_error, bus.func_error, bus.halt, bus.nop, bus.err}); end
    checks++; if (bus.valA !== 64'd0 || bus.valB !== 64'd0) begin errors++; $display("FAIL reset_operands got %h/%h want 0/0", bus.valA, bus.valB); end
    reset = 1'b0;
  endtask

  task automatic test_halt();
    load_byte(64'd0, 8'h00);
    bus.PC = 64'd0;
    step();
    checks++; if (bus.icode !== 4'h0) begin errors++; $display("FAIL halt_icode got %h want 0", bus.icode); end
    checks++; if (bus.halt !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", bus.halt); end
    checks++; if (bus.valP !== 64'd1) begin errors++; $display("FAIL halt_valP got %h want 1", bus.valP); end
    checks++; if (bus.mem_error !== 1'b0 || bus.func_error !== 1'b0 || bus.nop !== 1'b0) begin errors++; $display("FAIL halt_other_flags got %b%b%b want 000", bus.mem_error, bus.func_error, bus.nop); end
  endtask

  task automatic test_irmovq();
    logic [7:0] prog [10];
    prog = '{8'h30, 8'hF3, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 10; i++) load_byte(64'(i + 1), prog[i]);
    bus.PC      = 64'd1;
    bus.write   = 1'b1;
    bus.wr_addr = 4'd3;
    bus.data_in = 64'h0000_0000_CAFE_F00D;
    step();
    bus.write   = 1'b0;
    checks++; if (bus.icode !== 4'h3 || bus.ifun !== 4'h0) begin errors++; $display("FAIL irmovq_code got %h%h want 30", bus.icode, bus.ifun); end
    checks++; if (bus.rA !== 4'hF || bus.rB !== 4'h3) begin errors++; $display("FAIL irmovq_regs got %h%h want f3", bus.rA, bus.rB); end
    checks++; if (bus.valC !== 64'd10) begin errors++; $display("FAIL irmovq_valC got %h want a", bus.valC); end
    checks++; if (bus.valP !== 64'd11) begin errors++; $display("FAIL irmovq_valP got %h want b", bus.valP); end
    checks++; if (bus.valB !== 64'h0000_0000_CAFE_F00D || bus.valA !== 64'd0) begin errors++; $display("FAIL irmovq_operands got %h/%h want 0/cafef00d", bus.valA, bus.valB); end
    checks++; if (bus.halt !== 1'b0 || bus.func_error !== 1'b0 || bus.mem_error !== 1'b0) begin errors++; $display("FAIL irmovq_flags got %b%b%b want 000", bus.halt, bus.func_error, bus.mem_error); end
  endtask

  task automatic test_mem_bounds();
    logic [7:0] prog [10];
    prog = '{8'h30, 8'hF1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h30, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 10; i++) load_byte(64'(1014 + i), prog[i]);
    load_byte(64'd1024, 8'h10);
    bus.PC = 64'd1014;
    step();
    checks++; if (bus.mem_error !== 1'b0 || bus.valP !== 64'd1024) begin errors++; $display("FAIL edge_fit got err=%b valP=%h want 0/400", bus.mem_error, bus.valP); end
    checks++; if (bus.valC !== 64'h8877_6630_4433_2211 || bus.rB !== 4'h1) begin errors++; $display("FAIL edge_fit_fields got %h rB=%h want 8877663044332211/1", bus.valC, bus.rB); end
    bus.PC = 64'd1020;
    step();
    checks++; if (bus.mem_error !== 1'b1 || bus.icode !== 4'h0 || bus.valP !== 64'd1020) begin errors++; $display("FAIL edge_overrun got err=%b icode=%h valP=%h want 1/0/3fc", bus.mem_error, bus.icode, bus.valP); end
    checks++; if (bus.rA !== 4'hF || bus.rB !== 4'hF || bus.valC !== 64'd0 || bus.halt !== 1'b0) begin errors++; $display("FAIL edge_overrun_fields got %h%h %h %b want ff 0 0", bus.rA, bus.rB, bus.valC, bus.halt); end
    bus.PC = 64'd1024;
    step();
    checks++; if (bus.mem_error !== 1'b1 || bus.icode !== 4'h0 || bus.valP !== 64'd1024) begin errors++; $display("FAIL pc_out_of_range got err=%b icode=%h valP=%h want 1/0/400", bus.mem_error, bus.icode, bus.valP); end
    checks++; if (bus.halt !== 1'b0 || bus.nop !== 1'b0 || bus.func_error !== 1'b0) begin errors++; $display("FAIL pc_out_of_range_flags got %b%b%b want 000", bus.halt, bus.nop, bus.func_error); end
  endtask

  task automatic test_regfile();
    bus.write   = 1'b1;
    bus.wr_addr = 4'd2;
    bus.data_in = 64'h1234;
    step();
    bus.write   = 1'b0;
    load_byte(64'd20, 8'h20);
    load_byte(64'd21, 8'h2F);
    bus.PC = 64'd20;
    step();
    checks++; if (bus.icode !== 4'h2 || bus.rA !== 4'h2 || bus.rB !== 4'hF || bus.valP !== 64'd22) begin errors++; $display("FAIL rrmovq_fields got icode=%h rA=%h rB=%h valP=%h want 2/2/f/16", bus.icode, bus.rA, bus.rB, bus.valP); end
    checks++; if (bus.valA !== 64'h1234 || bus.valB !== 64'd0) begin errors++; $display("FAIL rrmovq_operands got %h/%h want 1234/0", bus.valA, bus.valB); end
    bus.write   = 1'b1;
    bus.wr_addr = 4'hF;
    bus.data_in = 64'hFFFF;
    #1;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_on_f got %b want 1", bus.err); end
    step();
    checks++; if (bus.valA !== 64'h1234) begin errors++; $display("FAIL err_no_change got %h want 1234", bus.valA); end
    bus.wr_addr = 4'd2;
    bus.data_in = 64'h5555;
    #1;
    checks++; if (bus.err !== 1'b0 || bus.valA !== 64'h1234) begin errors++; $display("FAIL write_old_value got err=%b valA=%h want 0/1234", bus.err, bus.valA); end
    step();
    bus.write   = 1'b0;
    checks++; if (bus.valA !== 64'h5555) begin errors++; $display("FAIL write_new_value got %h want 5555", bus.valA); end
  endtask

  task automatic test_func_error();
    load_byte(64'd30, 8'hC0);
    load_byte(64'd40, 8'h27);
    load_byte(64'd50, 8'h73);
    for (int i = 1; i <= 8; i++) load_byte(64'(50 + i), 8'(i));
    load_byte(64'd60, 8'h10);
    load_byte(64'd61, 8'h11);
    bus.PC = 64'd30;
    step();
    checks++; if (bus.func_error !== 1'b1 || bus.valP !== 64'd31 || bus.mem_error !== 1'b0) begin errors++; $display("FAIL bad_icode got ferr=%b valP=%h merr=%b want 1/1f/0", bus.func_error, bus.valP, bus.mem_error); end
    checks++; if (bus.rA !== 4'hF || bus.rB !== 4'hF || bus.valC !== 64'd0 || bus.halt !== 1'b0) begin errors++; $display("FAIL bad_icode_fields got %h%h %h %b want ff 0 0", bus.rA, bus.rB, bus.valC, bus.halt); end
    bus.PC = 64'd40;
    step();
    checks++; if (bus.func_error !== 1'b1 || bus.valP !== 64'd41 || bus.rA !== 4'hF) begin errors++; $display("FAIL bad_ifun got ferr=%b valP=%h rA=%h want 1/29/f", bus.func_error, bus.valP, bus.rA); end
    bus.PC = 64'd50;
    step();
    checks++; if (bus.func_error !== 1'b0 || bus.icode !== 4'h7 || bus.ifun !== 4'h3 || bus.valP !== 64'd59) begin errors++; $display("FAIL jxx got ferr=%b code=%h%h valP=%h want 0/73/3b", bus.func_error, bus.icode, bus.ifun, bus.valP); end
    checks++; if (bus.valC !== 64'h0807_0605_0403_0201 || bus.rA !== 4'hF || bus.rB !== 4'hF) begin errors++; $display("FAIL jxx_valC got %h rA=%h rB=%h want 0807060504030201/f/f", bus.valC, bus.rA, bus.rB); end
    bus.PC = 64'd60;
    step();
    checks++; if (bus.nop !== 1'b1 || bus.halt !== 1'b0 || bus.valP !== 64'd61) begin errors++; $display("FAIL nop got nop=%b halt=%b valP=%h want 1/0/3d", bus.nop, bus.halt, bus.valP); end
    bus.PC = 64'd61;
    step();
    checks++; if (bus.func_error !== 1'b1 || bus.nop !== 1'b0 || bus.valP !== 64'd62) begin errors++; $display("FAIL nop_bad_ifun got ferr=%b nop=%b valP=%h want 1/0/3e", bus.func_error, bus.nop, bus.valP); end
  endtask

  task automatic test_reset_after_writes();
    bus.PC      = 64'd20;
    bus.write   = 1'b1;
    bus.wr_addr = 4'd4;
    bus.data_in = 64'h9999;
    reset       = 1'b1;
    step();
    bus.write   = 1'b0;
    checks++; if (bus.rA !== 4'hF || bus.rB !== 4'hF || bus.valA !== 64'd0 || bus.valB !== 64'd0) begin errors++; $display("FAIL rst2_regs got %h%h %h/%h want ff 0/0", bus.rA, bus.rB, bus.valA, bus.valB); end
    checks++; if ({bus.mem_error, bus.func_error, bus.halt, bus.nop} !== 4'b0 || bus.valP !== 64'd0) begin errors++; $display("FAIL rst2_flags got %b valP=%h want 0000/0", {bus.mem_error, bus.func_error, bus.halt, bus.nop}, bus.valP); end
    reset = 1'b0;
    step();
    checks++; if (bus.rA !== 4'h2 || bus.valA !== 64'd0) begin errors++; $display("FAIL rst2_reg2_cleared got rA=%h valA=%h want 2/0", bus.rA, bus.valA); end
    bus.PC = 64'd1;
    step();
    checks++; if (bus.rB !== 4'h3 || bus.valB !== 64'd0 || bus.valC !== 64'd10) begin errors++; $display("FAIL rst2_mem_kept got rB=%h valB=%h valC=%h want 3/0/a", bus.rB, bus.valB, bus.valC); end
  endtask

  initial begin
    reset          = 1'b1;
    bus.PC         = '0;
    bus.imem_we    = 1'b0;
    bus.imem_addr  = '0;
    bus.imem_wdata = '0;
    bus.write      = 1'b0;
    bus.wr_addr    = '0;
    bus.data_in    = '0;
    test_reset();
    test_halt();
    test_irmovq();
    test_mem_bounds();
    test_regfile();
    test_func_error();
    test_reset_after_writes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
